// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver. A byte is captured on each rising edge of the
// receiver's done level. Reads are first-word-fall-through, and the FIFO reports occupancy and a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_SysClock,
  input  logic              i_ResetN,
  input  logic [7:0]        i_RxByte,
  input  logic              i_RxDone,
  input  logic              i_RdEn,
  output logic [7:0]        o_RdData,
  output logic              o_Empty,
  output logic              o_Full,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  input  logic              i_ClrOverflow
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              done_q, overflow;
  logic              wr_evt, rd_evt, wr_ok, wr_drop;

  // Consumer handshake: o_Empty=0 acts as valid and o_RdData is the head byte.
  // i_RdEn acts as ready. A pop happens only in a cycle where both are high.
  assign wr_evt  = i_RxDone & ~done_q;
  assign rd_evt  = i_RdEn & ~o_Empty;
  assign wr_ok   = wr_evt & (~o_Full | rd_evt);
  assign wr_drop = wr_evt & o_Full & ~rd_evt;

  assign o_Empty    = (count == '0);
  assign o_Full     = (count == CNT_FULL);
  assign o_Count    = count;
  assign o_Overflow = overflow;
  assign o_RdData   = o_Empty ? 8'h00 : mem[rd_ptr];

  // done_q resets high: the receiver idles with done high, so leaving reset is not an edge.
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      done_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      done_q <= i_RxDone;
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_evt) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_ok, rd_evt})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (wr_drop) overflow <= 1'b1;
      else if (i_ClrOverflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_SysClock) begin
    if (wr_ok) mem[wr_ptr] <= i_RxByte;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo. It runs a hand-checked vector table, hand-written corner sequences and random traffic.
// All results are checked against a queue-based model of the FIFO.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       rd_en;
  logic       clr_ovf;
  logic [7:0] rd_data;
  logic       empty, full, ovf;
  logic [4:0] count;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  logic       m_ovf;
  logic       m_prev_done;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .i_SysClock(clk), .i_ResetN(rst_n), .i_RxByte(rx_byte), .i_RxDone(rx_done),
    .i_RdEn(rd_en), .o_RdData(rd_data), .o_Empty(empty), .o_Full(full),
    .o_Count(count), .o_Overflow(ovf), .i_ClrOverflow(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_prev_done = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    if (exp_q.size() > 0) chk({tag, ".data"}, 32'(rd_data), 32'(exp_q[0]));
  endtask

  // Applies one clock of stimulus and advances the model.
  // It then samples the DUT 1 ns after the edge and checks it against the model.
  task automatic cycle(input logic done, input logic [7:0] b, input logic rden,
                       input logic clr, input string tag);
    logic wr, rd;
    rx_done = done; rx_byte = b; rd_en = rden; clr_ovf = clr;
    wr = done && !m_prev_done;
    rd = rden && exp_q.size() > 0;
    m_prev_done = done;
    if (clr) m_ovf = 1'b0;
    if (rd) void'(exp_q.pop_front());
    if (wr) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic write_byte(input logic [7:0] b, input string tag);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, tag);
    cycle(1'b1, b, 1'b0, 1'b0, tag);
  endtask

  typedef struct {
    logic       done;
    logic [7:0] b;
    logic       rden;
    logic       clr;
    logic [4:0] e_count;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[11];

  initial begin
    rst_n = 1'b0; rx_done = 1'b1; rx_byte = 8'h00; rd_en = 1'b0; clr_ovf = 1'b0;
    model_reset();
    #20;
    chk("reset.count", 32'(count), 0);
    chk("reset.empty", 32'(empty), 1);
    chk("reset.full", 32'(full), 0);
    chk("reset.ovf", 32'(ovf), 0);
    chk("reset.data", 32'(rd_data), 0);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "idle");

    // Each entry gives the inputs for one cycle and the outputs expected after that edge.
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[2]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[3]  = '{1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[8]  = '{1'b1, 8'h11, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[9]  = '{1'b1, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[10] = '{1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    foreach (vecs[i]) begin
      cycle(vecs[i].done, vecs[i].b, vecs[i].rden, vecs[i].clr, "vec");
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d.ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
      if (!vecs[i].e_empty) chk($sformatf("vec%0d.data", i), 32'(rd_data), 32'(vecs[i].e_data));
    end

    // Fill the FIFO, then overflow it, then write and pop in the same cycle while full.
    // Also apply a drop and a clear in the same cycle.
    for (int i = 0; i < 16; i++) write_byte(8'(i), "fill");
    chk("fill.full", 32'(full), 1);
    chk("fill.count", 32'(count), 16);
    write_byte(8'h55, "drop");
    chk("drop.ovf", 32'(ovf), 1);
    chk("drop.count", 32'(count), 16);
    cycle(1'b1, 8'h00, 1'b0, 1'b1, "clr");
    chk("clr.ovf", 32'(ovf), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "simul");
    cycle(1'b1, 8'h77, 1'b1, 1'b0, "simul");
    chk("simul.count", 32'(count), 16);
    chk("simul.ovf", 32'(ovf), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "setwin");
    cycle(1'b1, 8'h99, 1'b0, 1'b1, "setwin");
    chk("setwin.ovf", 32'(ovf), 1);
    cycle(1'b1, 8'h00, 1'b0, 1'b1, "clr2");
    chk("clr2.ovf", 32'(ovf), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d.data", i), 32'(rd_data), (i < 15) ? 32'(i + 1) : 32'h77);
      cycle(1'b1, 8'h00, 1'b1, 1'b0, "drain");
    end
    chk("drain.empty", 32'(empty), 1);

    // The write and read pointers wrap several times while the FIFO holds at most one entry.
    for (int i = 0; i < 40; i++) begin
      write_byte(8'(8'h80 + i), "wrap");
      chk($sformatf("wrap%0d.data", i), 32'(rd_data), 32'(8'h80 + i));
      cycle(1'b1, 8'h00, 1'b1, 1'b0, "wrap");
      chk($sformatf("wrap%0d.count", i), 32'(count), 0);
    end

    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)),
            (i < 1000) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), "rand");
    end

    // Reset taken between clock edges with three entries in the FIFO.
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'h00, 1'b1, 1'b0, "predrain");
    for (int i = 0; i < 3; i++) write_byte(8'(8'hC0 + i), "prerst");
    chk("prerst.count", 32'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.count", 32'(count), 0);
    chk("midrst.empty", 32'(empty), 1);
    chk("midrst.ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0, "postrst");
    write_byte(8'h42, "postrst.wr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Byte buffer directly downstream of the UART receiver. It detects each completed-byte event on the receiver's level-type done signal and captures the received byte into a synchronous circular FIFO. It presents bytes to the consumer with first-word-fall-through read semantics, plus occupancy, full/empty and sticky overflow status.

Parameters:
DEPTH, 16, number of byte entries; must be a power of 2 and at least 2.
ADDR_W, $clog2(DEPTH), localparam; pointer width. Count width is ADDR_W+1.

Ports:
i_SysClock  input  1  system clock; all logic on its rising edge
i_ResetN  input  1  asynchronous active-low reset
i_RxByte  input  8  received byte from the receiver; valid in the cycle i_RxDone rises
i_RxDone  input  1  receiver done level; high when idle or at the stop bit, low while receiving
i_RdEn  input  1  pop request from the consumer
o_RdData  output  8  head-of-FIFO byte (FWFT); meaningful only while o_Empty=0
o_Empty  output  1  FIFO holds 0 entries
o_Full  output  1  FIFO holds DEPTH entries
o_Count  output  ADDR_W+1  current occupancy, 0..DEPTH
o_Overflow  output  1  sticky flag: a byte was dropped because the FIFO was full
i_ClrOverflow  input  1  synchronous clear of o_Overflow

Behaviour:
- Reset (async, i_ResetN=0): wr_ptr=0, rd_ptr=0, count=0, o_Empty=1, o_Full=0, o_Count=0, o_Overflow=0, o_RdData=0.
- Edge-detect register done_q resets to 1. The receiver's done level is high out of reset, so a reset must not produce a spurious write.
- Write event: wr_evt = i_RxDone & ~done_q, where done_q <= i_RxDone every cycle.
  - i_RxByte is sampled in the same cycle wr_evt is asserted.
  - Only 0->1 transitions count. The level staying high across stop bit to idle gives exactly one event per byte.
  - Back-to-back frames (done falls directly from stop bit into the next start) give one event per frame.
- Read event: rd_evt = i_RdEn & ~o_Empty. i_RdEn while empty is ignored; no pointer or flag change.
- Write acceptance: wr_ok = wr_evt & (~o_Full | rd_evt). A write while full is accepted only if a pop occurs in the same cycle.
- Write dropped (wr_evt & o_Full & ~rd_evt):
  - o_Overflow <= 1; data is discarded; pointers and count are unchanged.
- Storage and pointers:
  - wr_ok: mem[wr_ptr] <= i_RxByte; wr_ptr <= wr_ptr+1.
  - rd_evt: rd_ptr <= rd_ptr+1.
  - Pointers are ADDR_W bits and wrap modulo DEPTH naturally.
- Count update:
  - wr_ok and not rd_evt: +1.
  - rd_evt and not wr_ok: -1.
  - Both or neither: unchanged.
- Flags: o_Empty = (count==0); o_Full = (count==DEPTH). Both are registered or derived from the registered count; no combinational path from inputs.
- FWFT: o_RdData = mem[rd_ptr] whenever o_Empty=0.
  - A byte written at edge N is visible on o_RdData and o_Empty=0 after edge N. Latency is 1 cycle from the wr_evt cycle.
  - After a pop at edge N, o_RdData shows the next entry after edge N.
- Overflow flag:
  - i_ClrOverflow clears o_Overflow on the next edge.
  - If a drop and a clear occur in the same cycle, set wins (o_Overflow=1).
- Simultaneous write + read, empty FIFO: the read is ignored, the write is accepted, count becomes 1.
- Simultaneous write + read, full FIFO: both occur, count stays DEPTH, no overflow.
- Reset mid-operation: all contents are invalidated (count=0). Memory contents need not be cleared.

Test Plan:
- Reset release with i_RxDone held 1 for 20 cycles -> no write; o_Empty=1, o_Count=0, o_Overflow=0.
- Drive i_RxDone 1->0->1 with i_RxByte=0xA5 at the rising edge and hold 1 for 10 cycles -> exactly one write; next cycle o_Count=1, o_RdData=0xA5. Pulse i_RdEn -> o_Empty=1.
- Write 0x00..0x0F (16 bytes, DEPTH=16), then a 17th byte 0x55 -> o_Full=1, o_Count=16, o_Overflow=1. Pop all -> sequence 0x00..0x0F in order, 0x55 absent. Pulse i_ClrOverflow -> o_Overflow=0.
- FIFO full: a write event and i_RdEn in the same cycle with byte 0x77 -> o_Count stays 16, o_Overflow=0, 0x77 is read last.
- Wrap-around: repeat 40 write/pop cycles with values 0x80+i -> every pop returns the matching value; o_Count is never above 1.
- i_RdEn asserted while empty for 5 cycles -> o_Count=0, pointers unchanged. Then write 0x3C -> o_RdData=0x3C. Assert i_ResetN=0 mid-stream with 3 entries -> o_Count=0, o_Empty=1 immediately.
